// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, FSM states and width helper for data_mem
package mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

   // ceiling log2, usable in constant expressions
   function automatic int log2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane steering, load extension and fault detection for one access
module mem_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                          we,
   input  logic [2:0]                    funct3,
   input  logic [log2(XLEN/8)-1:0]       off,
   input  logic [XLEN-1:0]               rword,
   input  logic [XLEN-1:0]               wdata,
   output logic [XLEN/8-1:0]             mask,
   output logic [XLEN-1:0]               wword,
   output logic [XLEN-1:0]               ldata,
   output logic                          misalign,
   output logic                          illegal
);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] sh;
   logic [NB-1:0]   base;

   always_comb begin
      misalign = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off[1:0] != 2'b00);
      illegal  = we ? (funct3[2] || funct3[1:0] == 2'b11) : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
      base     = funct3[1:0] == 2'b00 ? NB'(1) : funct3[1:0] == 2'b01 ? NB'(3) : NB'(15);
      mask     = base << off;
      wword    = wdata << {off, 3'b000};
      sh       = rword >> {off, 3'b000};
      ldata    = funct3 == F3_B  ? XLEN'($signed(sh[7:0]))  :
                 funct3 == F3_H  ? XLEN'($signed(sh[15:0])) :
                 funct3 == F3_W  ? XLEN'($signed(sh[31:0])) :
                 funct3 == F3_HU ? XLEN'(sh[15:0]) : XLEN'(sh[7:0]);
   end
endmodule

// File: rtl/data_mem.sv
// data_mem: byte-addressed load/store memory with handshake, wait states, faults and reset sweep
module data_mem
   import mem_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SIZE = 1024,
   parameter int WAIT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    we,
   input  logic [2:0]              funct3,
   input  logic [log2(SIZE)-1:0]   addr,
   input  logic [XLEN-1:0]         wdata,
   output logic [XLEN-1:0]         rdata,
   output logic                    resp_valid,
   output logic                    fault
);
   localparam int NB    = XLEN / 8;
   localparam int OB    = log2(NB);
   localparam int AW    = log2(SIZE);
   localparam int WORDS = SIZE / NB;
   localparam int WB    = log2(WORDS);
   localparam int CW    = WAIT > 1 ? log2(WAIT) : 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [WB-1:0]   ptr;
   logic            q_we;
   logic [2:0]      q_f3;
   logic [AW-1:0]   q_addr;
   logic [XLEN-1:0] q_wdata;
   logic [XLEN-1:0] mem [WORDS];
   logic [NB-1:0]   mask;
   logic [XLEN-1:0] wword, ldata;
   logic            misalign, illegal, bad;
   logic [WB-1:0]   widx;

   assign widx = q_addr[AW-1:OB];
   assign bad  = misalign || illegal;

   mem_align #(.XLEN(XLEN)) u_align (
      .we       (q_we),
      .funct3   (q_f3),
      .off      (q_addr[OB-1:0]),
      .rword    (mem[widx]),
      .wdata    (q_wdata),
      .mask     (mask),
      .wword    (wword),
      .ldata    (ldata),
      .misalign (misalign),
      .illegal  (illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_INIT;
         cnt        <= '0;
         ptr        <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         rdata      <= '0;
         fault      <= 1'b0;
         q_we       <= 1'b0;
         q_f3       <= '0;
         q_addr     <= '0;
         q_wdata    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_INIT: begin
               ptr <= ptr + 1'b1;
               if (ptr == WB'(WORDS - 1)) begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
               end
            end
            S_IDLE: if (req_valid && req_ready) begin
               q_we      <= we;
               q_f3      <= funct3;
               q_addr    <= addr;
               q_wdata   <= wdata;
               req_ready <= 1'b0;
               cnt       <= CW'(WAIT > 0 ? WAIT - 1 : 0);
               state     <= WAIT > 0 ? S_WAIT : S_RESP;
            end
            S_WAIT: if (cnt == '0) state <= S_RESP; else cnt <= cnt - 1'b1;
            S_RESP: begin
               resp_valid <= 1'b1;
               fault      <= bad;
               rdata      <= (bad || q_we) ? '0 : ldata;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_INIT;
         endcase
      end
   end

   // storage has no reset of its own: the INIT sweep clears it word by word
   always_ff @(posedge clk) begin
      if (state == S_INIT)
         mem[ptr] <= '0;
      else if (state == S_RESP && q_we && !bad)
         for (int i = 0; i < NB; i++)
            if (mask[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
   end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vectors and multi-cycle sequences for data_mem
module tb_data_mem;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rv0 = 1'b0, rv1 = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic        rdy0, rdy1, resp0, resp1, flt0, flt1;
   logic [31:0] rd0, rd1;

   int errs = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   data_mem #(.XLEN(32), .SIZE(64), .WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .we(we), .funct3(funct3),
      .addr(addr[5:0]), .wdata(wdata), .rdata(rd0), .resp_valid(resp0), .fault(flt0)
   );

   data_mem #(.XLEN(32), .SIZE(1024), .WAIT(3)) dut1 (
      .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .we(we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rd1), .resp_valid(resp1), .fault(flt1)
   );

   typedef struct {
      logic        w;
      logic [2:0]  f;
      logic [9:0]  a;
      logic [31:0] d;
      logic [31:0] er;
      logic        ef;
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // one transaction; lat counts negedges from the accept edge to the response, -1 on timeout
   task automatic xact(input bit sel, input logic w, input logic [2:0] f, input logic [9:0] a,
                       input logic [31:0] d, output logic [31:0] r, output logic fl, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!(sel ? rdy1 : rdy0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      we = w; funct3 = f; addr = a; wdata = d;
      if (sel) rv1 = 1'b1; else rv0 = 1'b1;
      @(posedge clk);
      #1;
      rv0 = 1'b0; rv1 = 1'b0;
      we = ~w; addr = ~a; wdata = ~d; funct3 = ~f;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(sel ? resp1 : resp0) && lat < 50);
      r  = sel ? rd1 : rd0;
      fl = sel ? flt1 : flt0;
      if (!(sel ? resp1 : resp0)) lat = -1;
   endtask

   initial begin
      vec_t        vecs[$];
      logic [31:0] r;
      logic        fl;
      int          lat, n, bad, seen, nrdy, rdy_only;
      int          times[$];

      vecs = '{
         '{1'b1, F3_W,   10'h010, 32'h80FF7F01, 32'h00000000, 1'b0, "sw10"},
         '{1'b1, F3_B,   10'h012, 32'h000000AA, 32'h00000000, 1'b0, "sb12"},
         '{1'b0, F3_W,   10'h010, 32'h0,        32'h80AA7F01, 1'b0, "lw10"},
         '{1'b0, F3_B,   10'h013, 32'h0,        32'hFFFFFF80, 1'b0, "lb13"},
         '{1'b0, F3_BU,  10'h013, 32'h0,        32'h00000080, 1'b0, "lbu13"},
         '{1'b0, F3_H,   10'h012, 32'h0,        32'hFFFF80AA, 1'b0, "lh12"},
         '{1'b0, F3_HU,  10'h012, 32'h0,        32'h000080AA, 1'b0, "lhu12"},
         '{1'b0, F3_H,   10'h011, 32'h0,        32'h00000000, 1'b1, "lh11_mis"},
         '{1'b1, F3_W,   10'h020, 32'h11223344, 32'h00000000, 1'b0, "sw20"},
         '{1'b1, F3_W,   10'h022, 32'hDEADBEEF, 32'h00000000, 1'b1, "sw22_mis"},
         '{1'b0, F3_W,   10'h020, 32'h0,        32'h11223344, 1'b0, "lw20_a"},
         '{1'b0, 3'b011, 10'h020, 32'h0,        32'h00000000, 1'b1, "ld011_ill"},
         '{1'b1, 3'b100, 10'h020, 32'hFFFFFFFF, 32'h00000000, 1'b1, "st100_ill"},
         '{1'b0, F3_W,   10'h020, 32'h0,        32'h11223344, 1'b0, "lw20_b"},
         '{1'b1, F3_H,   10'h022, 32'h0000BEEF, 32'h00000000, 1'b0, "sh22"},
         '{1'b0, F3_W,   10'h020, 32'h0,        32'hBEEF3344, 1'b0, "lw20_c"},
         '{1'b0, F3_B,   10'h021, 32'h0,        32'h00000033, 1'b0, "lb21"},
         '{1'b0, 3'b110, 10'h020, 32'h0,        32'h00000000, 1'b1, "ld110_ill"},
         '{1'b1, F3_W,   10'h040, 32'h0BADF00D, 32'h00000000, 1'b0, "sw40"},
         '{1'b1, F3_W,   10'h3FC, 32'hCAFEF00D, 32'h00000000, 1'b0, "sw3fc"},
         '{1'b0, F3_W,   10'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, "lw3fc"},
         '{1'b0, F3_H,   10'h3FF, 32'h0,        32'h00000000, 1'b1, "lh3ff_mis"},
         '{1'b0, F3_BU,  10'h3FF, 32'h0,        32'h000000CA, 1'b0, "lbu3ff"},
         '{1'b0, F3_H,   10'h3FE, 32'h0,        32'hFFFFCAFE, 1'b0, "lh3fe"},
         '{1'b0, F3_W,   10'h3FE, 32'h0,        32'h00000000, 1'b1, "lw3fe_mis"}
      };

      #1;
      chk("rst_ready", 32'(rdy1), 32'd0);
      chk("rst_resp",  32'(resp1), 32'd0);
      chk("rst_rdata", rd1, 32'd0);
      chk("rst_fault", 32'(flt1), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!rdy1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("init_cycles", 32'(n), 32'd256);

      foreach (vecs[i]) begin
         xact(1'b1, vecs[i].w, vecs[i].f, vecs[i].a, vecs[i].d, r, fl, lat);
         chk({vecs[i].name, "_rdata"}, r, vecs[i].er);
         chk({vecs[i].name, "_fault"}, 32'(fl), 32'(vecs[i].ef));
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'd5);
      end

      // back-to-back loads with req_valid held high: one response every WAIT+2 cycles
      @(negedge clk);
      we = 1'b0; funct3 = F3_W; addr = 10'h010; rv1 = 1'b1;
      nrdy = 0; rdy_only = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp1) begin
            times.push_back(c);
            chk("stream_rdata", rd1, 32'h80AA7F01);
         end
         if (rdy1) nrdy++;
         if (rdy1 && !resp1) rdy_only++;
      end
      rv1 = 1'b0;
      chk("stream_count", 32'(times.size()), 32'd4);
      chk("stream_first", 32'(times.size() > 0 ? times[0] : -1), 32'd5);
      for (int k = 1; k < times.size(); k++) chk("stream_gap", 32'(times[k] - times[k-1]), 32'd5);
      chk("stream_ready_cycles", 32'(nrdy), 32'd4);
      chk("stream_ready_extra", 32'(rdy_only), 32'd0);
      @(negedge clk);
      chk("resp_one_cycle", 32'(resp1), 32'd0);
      repeat (3) @(negedge clk);
      chk("rdata_hold", rd1, 32'h80AA7F01);

      // zero wait states on the small instance
      xact(1'b0, 1'b1, F3_W, 10'h008, 32'hA5A55A5A, r, fl, lat);
      chk("w0_sw_lat", 32'(lat), 32'd2);
      xact(1'b0, 1'b0, F3_W, 10'h008, 32'h0, r, fl, lat);
      chk("w0_lw_lat", 32'(lat), 32'd2);
      chk("w0_lw_rdata", r, 32'hA5A55A5A);
      xact(1'b0, 1'b0, F3_B, 10'h00B, 32'h0, r, fl, lat);
      chk("w0_lb_rdata", r, 32'hFFFFFFA5);

      // reset while a store is in its wait states
      @(negedge clk);
      we = 1'b1; funct3 = F3_W; addr = 10'h040; wdata = 32'h12345678; rv1 = 1'b1;
      @(posedge clk);
      #1 rv1 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp1) seen++;
      end
      rst = 1'b0;
      n = 0;
      while (!rdy1 && n < 400) begin
         @(negedge clk);
         if (resp1) seen++;
         n++;
      end
      chk("midrst_no_resp", 32'(seen), 32'd0);
      chk("midrst_init_cycles", 32'(n), 32'd256);
      xact(1'b1, 1'b0, F3_W, 10'h040, 32'h0, r, fl, lat);
      chk("midrst_lw40", r, 32'h0);

      // every word must have been cleared by the sweep, including ones written above
      bad = 0;
      for (int w = 0; w < 256; w++) begin
         xact(1'b1, 1'b0, F3_W, 10'(w * 4), 32'h0, r, fl, lat);
         if (r !== 32'h0 || fl !== 1'b0 || lat != 5) bad++;
      end
      chk("sweep_all_zero", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, n_chk);
      $finish;
   end
endmodule
